pwm_duty_decoder: RTL and testbench
===================================

# pwm_duty_decoder

Receive-side companion to the PWM generator: measures an incoming PWM waveform and reports its period, high time and duty cycle in 10% steps (0–10). It sits on the board-facing input of a control loop, or in the self-check bench next to the generator, and turns a 10 MHz PWM line on a 100 MHz system clock back into the duty setting that produced it. A timeout detects a stuck line and reports 0% or 100% accordingly.

## Interface
- CNT_W, 16, width of the period/high counters and measurement outputs
- TIMEOUT, 1000, cycles without a rising edge before the line is declared lost; 2 ≤ TIMEOUT ≤ 2^CNT_W−1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pwm_in  in  1  PWM line, asynchronous to clk
- period_out  out  CNT_W  last measured period in clk cycles
- high_out  out  CNT_W  last measured high time in clk cycles
- duty  out  4  duty cycle in tenths, 0..10
- duty_valid  out  1  one-cycle pulse when period_out/high_out/duty update
- signal_lost  out  1  level; 1 while no valid PWM is present

## Operation
- Input: 2-flop synchronizer gives pwm_s; pwm_d is pwm_s delayed one cycle; rise = pwm_s & ~pwm_d.
- States: IDLE (no reference edge yet), MEAS (counting), with an independent divider (DIV_IDLE, DIV_BUSY).
- Counters: on a rise cycle, cnt <= 1 and hi <= 1. Otherwise cnt <= cnt+1 and hi <= hi+1 if pwm_s=1. Both counters saturate at TIMEOUT.
- IDLE: the first rise moves to MEAS, clears signal_lost and starts the counters. No capture is made on this edge.
- MEAS, rise with divider idle: capture P = cnt and H = hi, then start the divider. Constraints: P ≥ 2 and 1 ≤ H < P.
- MEAS, rise with divider busy: the sample is dropped and no output update occurs. Counters still restart.
- Divider: computes duty = floor((10·H + P/2) / P) by restoring division.
  - Numerator N = 10·H + (P>>1), width CNT_W+5.
  - 4 iterations, i = 3..0: if N ≥ (P<<i), then N -= P<<i and set quotient bit i.
  - The result is always 0..10. No clamping is needed.
- Timeout: in MEAS, when cnt reaches TIMEOUT with no rise, the block sets:
  - period_out=0, high_out=0
  - duty = pwm_s ? 10 : 0
  - signal_lost=1 and a duty_valid pulse
  - state returns to IDLE
  - A divide in progress at timeout is aborted, with no separate pulse.
- Reset (asynchronous, any time, including mid-divide) sets:
  - state=IDLE, divider idle, counters 0
  - period_out=0, high_out=0, duty=0, duty_valid=0, signal_lost=1

## Timing
- Capture occurs on cycle T, the cycle where rise=1, which is 2–3 clk after the pwm_in edge because of the synchronizer.
- Divider iterations run on T+1..T+4. Outputs update and duty_valid=1 on cycle T+5, for exactly one cycle.
- period_out, high_out and duty update together on the same cycle as duty_valid and hold until the next update.
- Minimum period without dropped samples: 5 cycles. Shorter periods drop every rise that lands while the divider is busy.
- Timeout pulse: on the cycle after cnt first equals TIMEOUT.
- Rise and timeout in the same cycle: the rise wins, and cnt=TIMEOUT is captured as P.

## Test plan
- Reset, then pwm_in idle low: outputs hold 0, signal_lost=1, no duty_valid, until TIMEOUT+few cycles. No timeout pulse occurs in IDLE.
- 10-cycle period with 3 high cycles:
  - First rise gives no pulse and signal_lost→0.
  - Each later rise gives a duty_valid pulse exactly 5 cycles after rise, with period_out=10, high_out=3, duty=3.
- Step through high = 1..9 at period 10, matching the generator's ±10% steps: duty follows 1..9. Then period 20, high 15 gives duty=8 (7.5 rounds up).
- 4-cycle period with high 2: every second sample is dropped. Pulses carry period_out=4, high_out=2, duty=5.
- Timeout, two cases, each after valid PWM with TIMEOUT=50:
  - Line held high: one pulse with duty=10, period_out=0, signal_lost=1.
  - Line held low: one pulse with duty=0.
  - On resumed PWM, the first rise restarts without a pulse; valid pulses resume on later rises.
- Assert rst_n low 2 cycles after a capture (mid-divide): no duty_valid follows, and all outputs are at reset values immediately and asynchronously.

Source files
------------

// File: rtl/pwm_duty_decoder_if.sv
// Measurement bus of the PWM duty decoder: the raw PWM line in, the period/high/duty report out.
interface pwm_duty_decoder_if #(
  parameter int CNT_W = 16
) ();
  logic             pwm_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic [3:0]       duty;
  logic             duty_valid;
  logic             signal_lost;

  modport master (
    input  pwm_in,
    output period_out, high_out, duty, duty_valid, signal_lost
  );

  modport slave (
    output pwm_in,
    input  period_out, high_out, duty, duty_valid, signal_lost
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Measures an incoming PWM line: period, high time and duty in tenths, with stuck-line timeout.
//   state    | meaning
//   IDLE     | no reference rising edge yet (or line lost)
//   MEAS     | counting period/high since the last rising edge
//   DIV_IDLE | divider free, next rise in MEAS is captured
//   DIV_BUSY | restoring division of the captured sample in progress
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_duty_decoder_if.master bus
);

  localparam int               NW  = CNT_W + 5;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, MEAS} state_t;
  typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

  state_t           state, state_nxt;
  div_state_t       div_state, div_nxt;
  logic             sync1, pwm_s, pwm_d, rise;
  logic [CNT_W-1:0] cnt, hi, p_reg, h_reg;
  logic [CNT_W-1:0] period_r, high_r;
  logic [NW-1:0]    num, den_sh, num_sub;
  logic [1:0]       itr;
  logic [2:0]       quo;
  logic             ge;
  logic             capture, timeout, div_done;
  logic [3:0]       duty_r;
  logic             valid_r, lost_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= bus.pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  assign rise = pwm_s & ~pwm_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_state <= DIV_IDLE;
    end else begin
      state     <= state_nxt;
      div_state <= div_nxt;
    end
  end

  // A rise always beats a simultaneous timeout; timeout also aborts a running divide.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_state;
    capture   = 1'b0;
    timeout   = 1'b0;
    div_done  = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = MEAS;
      MEAS: begin
        if (rise) begin
          if (div_state == DIV_IDLE) capture = 1'b1;
        end else if (cnt == TMO) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    case (div_state)
      DIV_IDLE: if (capture) div_nxt = DIV_BUSY;
      DIV_BUSY: begin
        if (timeout) begin
          div_nxt = DIV_IDLE;
        end else if (itr == 2'd0) begin
          div_done = 1'b1;
          div_nxt  = DIV_IDLE;
        end
      end
      default: div_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      hi  <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
      hi  <= CNT_W'(1);
    end else if (state == MEAS) begin
      if (cnt != TMO)          cnt <= cnt + CNT_W'(1);
      if (pwm_s && hi != TMO)  hi  <= hi + CNT_W'(1);
    end
  end

  assign den_sh  = NW'(p_reg) << itr;
  assign ge      = (num >= den_sh);
  assign num_sub = num - den_sh;

  // Numerator carries +P/2 so the quotient rounds to nearest tenth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
      h_reg <= '0;
      num   <= '0;
      itr   <= 2'd0;
      quo   <= 3'd0;
    end else if (capture) begin
      p_reg <= cnt;
      h_reg <= hi;
      num   <= NW'(hi) * NW'(10) + NW'(cnt >> 1);
      itr   <= 2'd3;
      quo   <= 3'd0;
    end else if (div_state == DIV_BUSY) begin
      if (ge) num <= num_sub;
      quo <= {quo[1:0], ge};
      itr <= itr - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_r <= '0;
      high_r   <= '0;
      duty_r   <= 4'd0;
      valid_r  <= 1'b0;
      lost_r   <= 1'b1;
    end else begin
      valid_r <= 1'b0;
      if (timeout) begin
        period_r <= '0;
        high_r   <= '0;
        duty_r   <= pwm_s ? 4'd10 : 4'd0;
        lost_r   <= 1'b1;
        valid_r  <= 1'b1;
      end else if (div_done) begin
        period_r <= p_reg;
        high_r   <= h_reg;
        duty_r   <= {quo, ge};
        valid_r  <= 1'b1;
      end
      if (state == IDLE && rise) lost_r <= 1'b0;
    end
  end

  assign bus.period_out  = period_r;
  assign bus.high_out    = high_r;
  assign bus.duty        = duty_r;
  assign bus.duty_valid  = valid_r;
  assign bus.signal_lost = lost_r;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: PWM pulses predicted from edge times, monitor checks each report.
module tb_pwm_duty_decoder;

  localparam int CNT_W = 16;
  localparam int TMO   = 50;

  typedef struct {
    int t;
    int p;
    int h;
    int d;
    int lost;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t q[$];

  bit m_meas;
  int m_last_rise;
  int m_last_cap;
  int m_prev_h;

  pwm_duty_decoder_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_meas      = 1'b0;
    m_last_rise = -1000;
    m_last_cap  = -1000;
    m_prev_h    = 0;
  endtask

  // One PWM cycle: high for h cycles, low for p-h; the report expectations come from edge spacing.
  task automatic pulse(input int h, input int p);
    int   n;
    int   d;
    exp_t e;
    n = cyc;
    bus.pwm_in = 1'b1;
    if (m_meas) begin
      d = n - m_last_rise;
      if (n - m_last_cap >= 5) begin
        e.t = n + 7;
        e.p = d;
        e.h = m_prev_h;
        e.d = (20 * m_prev_h + d) / (2 * d);
        e.lost = 0;
        q.push_back(e);
        m_last_cap = n;
      end
    end else begin
      m_meas = 1'b1;
    end
    m_last_rise = n;
    m_prev_h    = h;
    if (p > TMO) begin
      e.t = n + 3 + TMO;
      e.p = 0;
      e.h = 0;
      e.d = (h > TMO) ? 10 : 0;
      e.lost = 1;
      q.push_back(e);
      m_meas = 1'b0;
    end
    repeat (h) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (p - h) @(negedge clk);
    if (p <= TMO) check("lost_while_measuring", int'(bus.signal_lost), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && cyc > q[0].t) begin
      total++;
      bad++;
      $display("FAIL missed_pulse actual=none required_cycle=%0d now=%0d", q[0].t, cyc);
      void'(q.pop_front());
    end
    if (bus.duty_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse actual=valid required=none cycle=%0d", cyc);
      end else begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.t);
        check("period_out", int'(bus.period_out), e.p);
        check("high_out", int'(bus.high_out), e.h);
        check("duty", int'(bus.duty), e.d);
        check("signal_lost", int'(bus.signal_lost), e.lost);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int h;
    total = 0;
    bad   = 0;
    model_reset();
    rst_n = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", int'(bus.period_out), 0);
    check("rst_high", int'(bus.high_out), 0);
    check("rst_duty", int'(bus.duty), 0);
    check("rst_valid", int'(bus.duty_valid), 0);
    check("rst_lost", int'(bus.signal_lost), 1);
    rst_n = 1'b1;

    repeat (TMO + 10) @(negedge clk);
    check("idle_lost", int'(bus.signal_lost), 1);
    check("idle_duty", int'(bus.duty), 0);

    repeat (5) pulse(3, 10);
    for (int i = 1; i <= 9; i++) begin
      pulse(i, 10);
      pulse(i, 10);
    end
    repeat (3) pulse(15, 20);
    repeat (8) pulse(2, 4);

    pulse(80, 90);
    repeat (3) pulse(5, 10);
    pulse(3, 80);
    repeat (3) pulse(4, 10);

    repeat (40) begin
      p = int'($urandom_range(60, 2));
      h = int'($urandom_range(p - 1, 1));
      pulse(h, p);
    end
    pulse(2, 70);

    pulse(5, 10);
    pulse(7, 10);
    bus.pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_period", int'(bus.period_out), 0);
    check("async_rst_high", int'(bus.high_out), 0);
    check("async_rst_duty", int'(bus.duty), 0);
    check("async_rst_valid", int'(bus.duty_valid), 0);
    check("async_rst_lost", int'(bus.signal_lost), 1);
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);

    repeat (4) pulse(4, 10);
    pulse(2, 70);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
